hazard_unit_mc: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage core. It generalises operand forwarding to NSRC execute operands and keeps load-use and branch stall/flush control. It adds a scoreboard for one multicycle unit (MUL/DIV) with fixed latency MC_LAT, plus a saturating stall-cycle counter. The block sits beside the pipeline registers and drives their stall/flush controls and the execute-stage forwarding muxes.

---
 rtl/hazard_unit_mc_if.sv | 36 +++
 rtl/hazard_unit_mc.sv | 79 +++++++
 tb/tb_hazard_unit_mc.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_mc_if.sv
// hazard_unit_mc_if: pipeline <-> hazard controller signal bundle
// master: pipeline side (drives D/E/M/W stage info, receives stall/flush/forward controls)
// slave : hazard controller side
interface hazard_unit_mc_if #(
  parameter int NSRC  = 3,
  parameter int AW    = 4,
  parameter int CNT_W = 32
);
  logic [NSRC*AW-1:0] RA_D;
  logic [NSRC-1:0]    RAvalidD;
  logic [AW-1:0]      WA_D;
  logic               RegWriteD;
  logic               MulStartD;
  logic [NSRC*AW-1:0] RA_E;
  logic [AW-1:0]      WA_E, WA_M, WA_W;
  logic               MemToRegE, RegWriteM, RegWriteW;
  logic               MulStartE;
  logic               PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic [2*NSRC-1:0]  ForwardE;
  logic               StallF, StallD, FlushE, FlushD;
  logic               MCBusy, MCDone, MCErr;
  logic [AW-1:0]      MCDest;
  logic [CNT_W-1:0]   StallCount;
  modport master (
    output RA_D, RAvalidD, WA_D, RegWriteD, MulStartD, RA_E, WA_E, WA_M, WA_W,
           MemToRegE, RegWriteM, RegWriteW, MulStartE,
           PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
    input  ForwardE, StallF, StallD, FlushE, FlushD, MCBusy, MCDone, MCErr, MCDest, StallCount
  );
  modport slave (
    input  RA_D, RAvalidD, WA_D, RegWriteD, MulStartD, RA_E, WA_E, WA_M, WA_W,
           MemToRegE, RegWriteM, RegWriteW, MulStartE,
           PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
    output ForwardE, StallF, StallD, FlushE, FlushD, MCBusy, MCDone, MCErr, MCDest, StallCount
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding, load-use/branch stall-flush and multicycle-unit scoreboard
// clk, reset (async active-low); h: hazard_unit_mc_if.slave carrying stage addresses,
// write enables and branch info in, ForwardE/Stall*/Flush*/MC*/StallCount out
module hazard_unit_mc #(
  parameter int NSRC   = 3,
  parameter int AW     = 4,
  parameter int PC_REG = 15,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input logic clk,
  input logic reset,
  hazard_unit_mc_if.slave h
);
  localparam int NREG = 2**AW;
  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [AW-1:0] PC = AW'(PC_REG);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [AW-1:0] dest;
  logic [NREG-1:0] sb;
  logic [CNT_W-1:0] count;
  logic err, accept, mc_done, ldr_stall, mc_stall, pc_pend, stall_d;
  logic [2*NSRC-1:0] fwd;
  // cnt loads MC_LAT-2 so MCDone lands MC_LAT-1 cycles after the issue cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      dest  <= '0;
      sb    <= '0;
      err   <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nx;
      cnt   <= accept ? CW'(MC_LAT-2) : (state == RUN && cnt != '0) ? cnt - 1'b1 : cnt;
      if (accept) dest <= h.WA_E;
      if (accept && h.WA_E != PC) sb[h.WA_E] <= 1'b1;
      if (mc_done) sb[dest] <= 1'b0;
      if (h.MulStartE && state == RUN) err <= 1'b1;
      if (stall_d && ~&count) count <= count + 1'b1;
    end
  always_comb
    state_nx = (state == IDLE) ? (h.MulStartE ? RUN : IDLE) : (cnt == '0 ? IDLE : RUN);
  always_comb begin
    accept  = h.MulStartE && state == IDLE;
    mc_done = state == RUN && cnt == '0;
  end
  always_comb begin
    fwd = '0;
    for (int i = 0; i < NSRC; i++)
      fwd[2*i +: 2] = (h.RA_E[i*AW +: AW] == PC) ? 2'b00 :
                      (h.RegWriteM && h.RA_E[i*AW +: AW] == h.WA_M) ? 2'b10 :
                      (h.RegWriteW && h.RA_E[i*AW +: AW] == h.WA_W) ? 2'b01 : 2'b00;
  end
  always_comb begin
    ldr_stall = 1'b0;
    mc_stall  = 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (h.RAvalidD[i] && h.RA_D[i*AW +: AW] != PC) begin
        ldr_stall |= h.MemToRegE && h.RA_D[i*AW +: AW] == h.WA_E;
        mc_stall  |= sb[h.RA_D[i*AW +: AW]];
      end
    mc_stall |= (h.RegWriteD && h.WA_D != PC && sb[h.WA_D]) || (h.MulStartD && state == RUN);
    stall_d = ldr_stall || mc_stall;
    pc_pend = h.PCSrcD || h.PCSrcE || h.PCSrcM;
  end
  assign h.ForwardE   = fwd;
  assign h.StallD     = stall_d;
  assign h.StallF     = stall_d || pc_pend;
  assign h.FlushE     = stall_d || h.BranchTakenE;
  assign h.FlushD     = (pc_pend || h.PCSrcW || h.BranchTakenE) && !stall_d;
  assign h.MCBusy     = state == RUN;
  assign h.MCDone     = mc_done;
  assign h.MCDest     = dest;
  assign h.MCErr      = err;
  assign h.StallCount = count;
endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: table-driven and sequence checks of hazard_unit_mc
module tb_hazard_unit_mc;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  hazard_unit_mc_if #(.NSRC(3), .AW(4), .CNT_W(32)) h();
  hazard_unit_mc #(.NSRC(3), .AW(4), .PC_REG(15), .MC_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .h(h)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [11:0] ra_e;
    logic [3:0]  wa_m, wa_w;
    logic        rwm, rww, mtr;
    logic [3:0]  wa_e;
    logic [11:0] ra_d;
    logic [2:0]  rav;
    logic [4:0]  br;
    logic [5:0]  fwd;
    logic [3:0]  ctl;
  } vec_t;
  vec_t tbl [13];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    h.RA_D = '0; h.RAvalidD = '0; h.WA_D = '0; h.RegWriteD = 1'b0; h.MulStartD = 1'b0;
    h.RA_E = '0; h.WA_E = '0; h.WA_M = '0; h.WA_W = '0;
    h.MemToRegE = 1'b0; h.RegWriteM = 1'b0; h.RegWriteW = 1'b0; h.MulStartE = 1'b0;
    h.PCSrcD = 1'b0; h.PCSrcE = 1'b0; h.PCSrcM = 1'b0; h.PCSrcW = 1'b0; h.BranchTakenE = 1'b0;
  endtask
  initial begin
    tbl[0]  = '{12'h003, 4'd3,  4'd3,  1'b1, 1'b1, 1'b0, 4'd0,  12'h000, 3'b000, 5'b00000, 6'b000010, 4'b0000};
    tbl[1]  = '{12'h003, 4'd3,  4'd3,  1'b0, 1'b1, 1'b0, 4'd0,  12'h000, 3'b000, 5'b00000, 6'b000001, 4'b0000};
    tbl[2]  = '{12'h00F, 4'd15, 4'd15, 1'b1, 1'b1, 1'b0, 4'd0,  12'h000, 3'b000, 5'b00000, 6'b000000, 4'b0000};
    tbl[3]  = '{12'h359, 4'd5,  4'd3,  1'b1, 1'b1, 1'b0, 4'd0,  12'h000, 3'b000, 5'b00000, 6'b011000, 4'b0000};
    tbl[4]  = '{12'h000, 4'd0,  4'd0,  1'b0, 1'b0, 1'b1, 4'd5,  12'h050, 3'b010, 5'b00000, 6'b000000, 4'b1110};
    tbl[5]  = '{12'h000, 4'd0,  4'd0,  1'b0, 1'b0, 1'b1, 4'd5,  12'h050, 3'b101, 5'b00000, 6'b000000, 4'b0000};
    tbl[6]  = '{12'h000, 4'd0,  4'd0,  1'b0, 1'b0, 1'b1, 4'd15, 12'h0F0, 3'b010, 5'b00000, 6'b000000, 4'b0000};
    tbl[7]  = '{12'h000, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  12'h000, 3'b000, 5'b01000, 6'b000000, 4'b1001};
    tbl[8]  = '{12'h000, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  12'h000, 3'b000, 5'b00001, 6'b000000, 4'b0011};
    tbl[9]  = '{12'h000, 4'd0,  4'd0,  1'b0, 1'b0, 1'b1, 4'd5,  12'h050, 3'b010, 5'b00001, 6'b000000, 4'b1110};
    tbl[10] = '{12'h000, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  12'h000, 3'b000, 5'b00010, 6'b000000, 4'b0001};
    tbl[11] = '{12'h000, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  12'h000, 3'b000, 5'b10000, 6'b000000, 4'b1001};
    tbl[12] = '{12'h000, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  12'h000, 3'b000, 5'b00100, 6'b000000, 4'b1001};
    idle;
    #2;
    chk("rst_ctl", {h.StallF, h.StallD, h.FlushE, h.FlushD}, 4'b0000);
    chk("rst_busy", h.MCBusy, 1'b0);
    chk("rst_err", h.MCErr, 1'b0);
    chk("rst_cnt", h.StallCount, 32'd0);
    chk("rst_dest", h.MCDest, 4'd0);
    #10 reset = 1'b1;
    tick;
    for (int i = 0; i < 13; i++) begin
      h.RA_E = tbl[i].ra_e; h.WA_M = tbl[i].wa_m; h.WA_W = tbl[i].wa_w;
      h.RegWriteM = tbl[i].rwm; h.RegWriteW = tbl[i].rww; h.MemToRegE = tbl[i].mtr;
      h.WA_E = tbl[i].wa_e; h.RA_D = tbl[i].ra_d; h.RAvalidD = tbl[i].rav;
      {h.PCSrcD, h.PCSrcE, h.PCSrcM, h.PCSrcW, h.BranchTakenE} = tbl[i].br;
      #2;
      chk($sformatf("vec%0d_fwd", i), h.ForwardE, tbl[i].fwd);
      chk($sformatf("vec%0d_ctl", i), {h.StallF, h.StallD, h.FlushE, h.FlushD}, tbl[i].ctl);
      tick;
    end
    idle;
    #2;
    chk("cnt_after_table", h.StallCount, 32'd2);
    // RAW on multicycle result, consumer right behind the issuer
    h.MulStartE = 1'b1; h.WA_E = 4'd7; h.RA_D = 12'h007; h.RAvalidD = 3'b001;
    #2;
    chk("raw_t0_stall", h.StallD, 1'b0);
    chk("raw_t0_busy", h.MCBusy, 1'b0);
    tick;
    h.MulStartE = 1'b0; h.WA_E = 4'd0;
    for (int c = 1; c <= 3; c++) begin
      #2;
      chk($sformatf("raw_t%0d_stall", c), h.StallD, 1'b1);
      chk($sformatf("raw_t%0d_busy", c), h.MCBusy, 1'b1);
      chk($sformatf("raw_t%0d_done", c), h.MCDone, c == 3);
      if (c == 3) chk("raw_dest", h.MCDest, 4'd7);
      tick;
    end
    #2;
    chk("raw_t4_stall", h.StallD, 1'b0);
    chk("raw_t4_busy", h.MCBusy, 1'b0);
    chk("raw_t4_done", h.MCDone, 1'b0);
    // back-to-back issue in the cycle after MCDone
    h.MulStartE = 1'b1; h.WA_E = 4'd2; h.RAvalidD = 3'b000;
    tick;
    h.MulStartE = 1'b0;
    #2;
    chk("b2b_busy", h.MCBusy, 1'b1);
    tick;
    tick;
    #2;
    chk("b2b_done", h.MCDone, 1'b1);
    chk("b2b_dest", h.MCDest, 4'd2);
    tick;
    #2;
    chk("b2b_idle", h.MCBusy, 1'b0);
    chk("cnt_after_raw", h.StallCount, 32'd5);
    // structural, WAW and issue-while-busy error
    idle;
    h.MulStartE = 1'b1; h.WA_E = 4'd7;
    tick;
    idle;
    h.MulStartD = 1'b1;
    #2;
    chk("struct_stall", h.StallD, 1'b1);
    tick;
    h.MulStartD = 1'b0; h.RegWriteD = 1'b1; h.WA_D = 4'd7;
    h.MulStartE = 1'b1; h.WA_E = 4'd3;
    #2;
    chk("waw_stall", h.StallD, 1'b1);
    chk("err_before", h.MCErr, 1'b0);
    tick;
    idle;
    h.RA_D = 12'h003; h.RAvalidD = 3'b001;
    #2;
    chk("err_set", h.MCErr, 1'b1);
    chk("err_done", h.MCDone, 1'b1);
    chk("err_dest", h.MCDest, 4'd7);
    chk("err_no_sb", h.StallD, 1'b0);
    tick;
    #2;
    chk("err_idle", h.MCBusy, 1'b0);
    chk("err_sticky", h.MCErr, 1'b1);
    chk("cnt_after_err", h.StallCount, 32'd7);
    // reset in the middle of a multicycle op
    idle;
    h.MulStartE = 1'b1; h.WA_E = 4'd7; h.RA_D = 12'h007; h.RAvalidD = 3'b001;
    tick;
    h.MulStartE = 1'b0; h.WA_E = 4'd0;
    #2;
    chk("mid_stall", h.StallD, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", h.MCBusy, 1'b0);
    chk("mid_rst_stall", h.StallD, 1'b0);
    chk("mid_rst_cnt", h.StallCount, 32'd0);
    chk("mid_rst_err", h.MCErr, 1'b0);
    #2 reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      #2;
      chk($sformatf("post_rst%0d_done", c), h.MCDone, 1'b0);
      chk($sformatf("post_rst%0d_stall", c), h.StallD, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
